pipelined_carry_adder: RTL

Parametrised, pipelined successor to the team's 4-bit ripple-carry adder. Splits a WIDTH-bit add/subtract into STAGES equal chunks, resolves one chunk per clock, and registers each chunk's carry into the next stage. Accepts one operation per cycle, with valid/ready flow control on both sides. It serves as the datapath adder wherever a combinational WIDTH-bit ripple chain would break timing.

---
 rtl/pipelined_carry_adder_if.sv | 26 ++
 rtl/pipelined_carry_adder.sv | 95 +++++++++
 2 files changed

// File: rtl/pipelined_carry_adder_if.sv
// Operand/result bundle for pipelined_carry_adder: valid/ready on both sides.
interface pipelined_carry_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit add/sub resolved CHUNK bits per stage; result STAGES register stages after accept.
// A stalled output (out_valid && !out_ready) freezes every stage and deasserts in_ready.
module pipelined_carry_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic                    clk,
    input logic                    rst,
    pipelined_carry_adder_if.slave io
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int CW    = CHUNK + 1;
    localparam int LAST  = STAGES - 1;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [CW-1:0]     part [STAGES];
    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic              adv;

    always_comb begin
        adv   = !(vld_q[LAST] && !io.out_ready);
        b_eff = io.sub ? ~io.b : io.b;
        c0    = io.sub ? 1'b1 : io.cin;
        vld_d = vld_q;
        c_d   = c_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]  = a_q[k];
            b_d[k]  = b_q[k];
            s_d[k]  = s_q[k];
            part[k] = '0;
        end

        if (adv) begin
            vld_d[0] = io.in_valid;
            if (io.in_valid) begin
                part[0] = {1'b0, io.a[CHUNK-1:0]} + {1'b0, b_eff[CHUNK-1:0]} + CW'(c0);
                a_d[0]  = io.a;
                b_d[0]  = b_eff;
                s_d[0]  = '0;
                s_d[0][CHUNK-1:0] = part[0][CHUNK-1:0];
                c_d[0]  = part[0][CHUNK];
            end
            // Stage k resolves chunk k; lower chunks ride along unchanged in s_q.
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    part[k] = {1'b0, a_q[k-1][k*CHUNK +: CHUNK]}
                            + {1'b0, b_q[k-1][k*CHUNK +: CHUNK]}
                            + CW'(c_q[k-1]);
                    a_d[k]  = a_q[k-1];
                    b_d[k]  = b_q[k-1];
                    s_d[k]  = s_q[k-1];
                    s_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
                    c_d[k]  = part[k][CHUNK];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            c_q   <= c_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign io.in_ready  = adv;
    assign io.out_valid = vld_q[LAST];
    assign io.sum       = s_q[LAST];
    assign io.cout      = c_q[LAST];
    // Overflow uses b after inversion, so one rule covers add and subtract.
    assign io.ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                       && (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
endmodule
